// File: rtl/lap_split_capture.sv
// lap_split_capture: lap capture buffer with frozen split display and lap recall
module lap_split_capture #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     lap_btn_n,
  input  logic                     recall_btn_n,
  input  logic [3:0]               live_cs_ones,
  input  logic [3:0]               live_cs_tens,
  input  logic [3:0]               live_sec_ones,
  input  logic [3:0]               live_sec_tens,
  output logic [3:0]               disp_cs_ones,
  output logic [3:0]               disp_cs_tens,
  output logic [3:0]               disp_sec_ones,
  output logic [3:0]               disp_sec_tens,
  output logic [$clog2(DEPTH):0]   lap_count,
  output logic [$clog2(DEPTH)-1:0] shown_index,
  output logic                     hold_active,
  output logic                     recall_active,
  output logic                     lap_full,
  output logic                     overflow
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int TW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {LIVE, HOLD, RECALL} state_t;

  state_t         state_q, state_d;
  logic           lap_prev_q, rec_prev_q;
  logic [15:0]    snap_q, snap_d, disp_q, disp_d;
  logic [15:0]    buf_q [DEPTH];
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]  shown_q, shown_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           ovf_q, ovf_d, we;
  logic           lap_p, rec_p;
  logic [15:0]    live;

  assign live          = {live_sec_tens, live_sec_ones, live_cs_tens, live_cs_ones};
  assign lap_p         = lap_prev_q & ~lap_btn_n;
  assign rec_p         = rec_prev_q & ~recall_btn_n;
  assign lap_full      = cnt_q == CW'(DEPTH);
  assign lap_count     = cnt_q;
  assign shown_index   = shown_q;
  assign overflow      = ovf_q;
  assign hold_active   = state_q == HOLD;
  assign recall_active = state_q == RECALL;
  assign {disp_sec_tens, disp_sec_ones, disp_cs_tens, disp_cs_ones} = disp_q;

  // Next-state: hold countdown first, then events in priority clear > lap > recall
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shown_d = shown_q;
    ovf_d   = ovf_q;
    snap_d  = snap_q;
    timer_d = timer_q;
    we      = 1'b0;
    if (state_q == HOLD) begin
      timer_d = timer_q == '0 ? '0 : timer_q - TW'(1);
      state_d = timer_q == '0 ? LIVE : HOLD;
    end
    if (clear) begin
      state_d = LIVE;
      cnt_d   = '0;
      shown_d = '0;
      ovf_d   = 1'b0;
      timer_d = '0;
    end else if (lap_p) begin
      if (state_q != RECALL) begin
        snap_d  = live;
        we      = !lap_full;
        cnt_d   = lap_full ? cnt_q : cnt_q + CW'(1);
        ovf_d   = ovf_q | lap_full;
        state_d = HOLD;
        timer_d = TW'(HOLD_CYCLES - 1);
      end
    end else if (rec_p) begin
      if (state_q != RECALL) begin
        if (cnt_q != '0) begin
          state_d = RECALL;
          shown_d = '0;
          timer_d = '0;
        end
      end else if ({1'b0, shown_q} == cnt_q - CW'(1)) begin
        state_d = LIVE;
        shown_d = '0;
      end else begin
        shown_d = shown_q + IW'(1);
      end
    end
    disp_d = state_d == HOLD ? snap_d : state_d == RECALL ? buf_q[shown_d] : live;
  end

  // State, counters, edge history and registered display
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= LIVE;
      cnt_q      <= '0;
      shown_q    <= '0;
      ovf_q      <= 1'b0;
      timer_q    <= '0;
      snap_q     <= '0;
      disp_q     <= '0;
      lap_prev_q <= 1'b1;
      rec_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shown_q    <= shown_d;
      ovf_q      <= ovf_d;
      timer_q    <= timer_d;
      snap_q     <= snap_d;
      disp_q     <= disp_d;
      lap_prev_q <= lap_btn_n;
      rec_prev_q <= recall_btn_n;
    end
  end

  // Lap storage; contents are don't-care after reset so no reset term
  always_ff @(posedge clk) begin
    if (rst_n && we) buf_q[cnt_q[IW-1:0]] <= snap_d;
  end
endmodule

// File: tb/tb_lap_split_capture.sv
// tb_lap_split_capture: directed self-checking bench for lap_split_capture
module tb_lap_split_capture;
  logic clk = 1'b0;
  logic rst_n, clear, lap_btn_n, recall_btn_n;
  logic [3:0] l_co, l_ct, l_so, l_st, d_co, d_ct, d_so, d_st;
  logic [2:0] lap_count;
  logic [1:0] shown_index;
  logic hold_active, recall_active, lap_full, overflow;
  logic [15:0] disp;
  int checks = 0;
  int errors = 0;

  assign disp = {d_st, d_so, d_ct, d_co};

  lap_split_capture #(.DEPTH(4), .HOLD_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .lap_btn_n(lap_btn_n), .recall_btn_n(recall_btn_n),
    .live_cs_ones(l_co), .live_cs_tens(l_ct), .live_sec_ones(l_so), .live_sec_tens(l_st),
    .disp_cs_ones(d_co), .disp_cs_tens(d_ct), .disp_sec_ones(d_so), .disp_sec_tens(d_st),
    .lap_count(lap_count), .shown_index(shown_index), .hold_active(hold_active),
    .recall_active(recall_active), .lap_full(lap_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_live(input logic [15:0] v);
    {l_st, l_so, l_ct, l_co} = v;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_disp"}, disp, 16'h0000);
    chk({tag, "_cnt"}, 16'(lap_count), 16'd0);
    chk({tag, "_shown"}, 16'(shown_index), 16'd0);
    chk({tag, "_flags"}, 16'({hold_active, recall_active, lap_full, overflow}), 16'd0);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; lap_btn_n = 1'b1; recall_btn_n = 1'b1;
    set_live(16'h0000);
    tick(); tick();
    chk_reset("reset");
    set_live(16'h1234);
    tick();
    chk("reset_cycle_disp", disp, 16'h0000);
    rst_n = 1'b1;
    tick();
    chk("live_latency", disp, 16'h1234);
    chk("live_cnt", 16'(lap_count), 16'd0);
    chk("live_ovf", 16'(overflow), 16'd0);

    recall_btn_n = 1'b0;
    tick();
    chk("recall_empty_act", 16'(recall_active), 16'd0);
    chk("recall_empty_disp", disp, 16'h1234);
    recall_btn_n = 1'b1;
    tick();

    set_live(16'h0567);
    lap_btn_n = 1'b0;
    tick();
    lap_btn_n = 1'b1;
    chk("hold_disp_0", disp, 16'h0567);
    chk("hold_act_0", 16'(hold_active), 16'd1);
    chk("hold_cnt", 16'(lap_count), 16'd1);
    for (int i = 1; i < 8; i++) begin
      set_live(16'h0570 + 16'(i));
      tick();
      chk($sformatf("hold_disp_%0d", i), disp, 16'h0567);
      chk($sformatf("hold_act_%0d", i), 16'(hold_active), 16'd1);
    end
    set_live(16'h0580);
    tick();
    chk("hold_end_act", 16'(hold_active), 16'd0);
    chk("hold_end_disp", disp, 16'h0580);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_cnt", 16'(lap_count), 16'd0);

    for (int k = 1; k <= 5; k++) begin
      set_live({8'h00 | 8'(k), 8'h00});
      lap_btn_n = 1'b0;
      tick();
      lap_btn_n = 1'b1;
      if (k == 4) begin
        chk("four_cnt", 16'(lap_count), 16'd4);
        chk("four_full", 16'(lap_full), 16'd1);
        chk("four_ovf", 16'(overflow), 16'd0);
      end
      tick();
    end
    chk("five_cnt", 16'(lap_count), 16'd4);
    chk("five_full", 16'(lap_full), 16'd1);
    chk("five_ovf", 16'(overflow), 16'd1);
    chk("five_snap", disp, 16'h0500);

    for (int k = 0; k < 4; k++) begin
      recall_btn_n = 1'b0;
      tick();
      recall_btn_n = 1'b1;
      chk($sformatf("recall_act_%0d", k), 16'(recall_active), 16'd1);
      chk($sformatf("recall_idx_%0d", k), 16'(shown_index), 16'(k));
      chk($sformatf("recall_disp_%0d", k), disp, {8'(k + 1), 8'h00});
      tick();
    end
    set_live(16'h0987);
    recall_btn_n = 1'b0;
    tick();
    recall_btn_n = 1'b1;
    chk("recall_exit_act", 16'(recall_active), 16'd0);
    chk("recall_exit_idx", 16'(shown_index), 16'd0);
    chk("recall_exit_disp", disp, 16'h0987);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_ovf", 16'(overflow), 16'd0);
    chk("clear_full", 16'(lap_full), 16'd0);
    set_live(16'h0111);
    lap_btn_n = 1'b0;
    tick();
    lap_btn_n = 1'b1;
    repeat (9) tick();
    chk("one_lap_live", 16'(hold_active), 16'd0);
    set_live(16'h0222);
    lap_btn_n = 1'b0;
    recall_btn_n = 1'b0;
    tick();
    lap_btn_n = 1'b1;
    recall_btn_n = 1'b1;
    chk("both_cnt", 16'(lap_count), 16'd2);
    chk("both_hold", 16'(hold_active), 16'd1);
    chk("both_recall", 16'(recall_active), 16'd0);
    chk("both_disp", disp, 16'h0222);
    tick();

    set_live(16'h0333);
    clear = 1'b1;
    lap_btn_n = 1'b0;
    tick();
    clear = 1'b0;
    lap_btn_n = 1'b1;
    chk("clr_hold_act", 16'(hold_active), 16'd0);
    chk("clr_hold_cnt", 16'(lap_count), 16'd0);
    chk("clr_hold_disp", disp, 16'h0333);
    tick();

    set_live(16'h0444);
    lap_btn_n = 1'b0;
    tick();
    lap_btn_n = 1'b1;
    tick();
    recall_btn_n = 1'b0;
    tick();
    recall_btn_n = 1'b1;
    chk("pre_clr_recall", 16'(recall_active), 16'd1);
    chk("pre_clr_disp", disp, 16'h0444);
    tick();
    set_live(16'h0456);
    clear = 1'b1;
    lap_btn_n = 1'b0;
    tick();
    clear = 1'b0;
    lap_btn_n = 1'b1;
    chk("clr_rec_act", 16'(recall_active), 16'd0);
    chk("clr_rec_hold", 16'(hold_active), 16'd0);
    chk("clr_rec_cnt", 16'(lap_count), 16'd0);
    chk("clr_rec_ovf", 16'(overflow), 16'd0);
    chk("clr_rec_disp", disp, 16'h0456);
    tick();

    set_live(16'h0555);
    lap_btn_n = 1'b0;
    tick();
    lap_btn_n = 1'b1;
    tick();
    chk("pre_rst_hold", 16'(hold_active), 16'd1);
    rst_n = 1'b0;
    tick();
    chk_reset("rst_mid_hold");
    rst_n = 1'b1;
    tick();
    chk("post_rst_disp", disp, 16'h0555);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
